// File: rtl/drac_pkg.sv
// drac_pkg: shared state encodings for the tile reset/wake-up sequencer
package drac_pkg;
  typedef enum logic [1:0] {RESET, WAKEUP, RELEASE, RUN} rst_seq_state_t;
  typedef enum logic [2:0] {IDLE, DRAIN, ASSERT, ACK, WAIT} hart_srst_state_t;
endpackage

// File: rtl/drac_hart_soft_rst.sv
// drac_hart_soft_rst: per-hart soft reset with drain handshake, timeout and ack
module drac_hart_soft_rst
  import drac_pkg::*;
#(
  parameter int unsigned DrainTimeout  = 1024,
  parameter int unsigned SoftRstCycles = 16
) (
  input  logic clk_i,
  input  logic reset_l,
  input  logic run_i,
  input  logic rel_d_i,
  input  logic req_i,
  input  logic idle_i,
  output logic soft_rstn_o,
  output logic fetch_hold_o,
  output logic ack_o,
  output logic timeout_o
);
  localparam int unsigned CntMax = DrainTimeout > SoftRstCycles ? DrainTimeout : SoftRstCycles;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DrainLast = CntW'(DrainTimeout - 1);
  localparam logic [CntW-1:0] SoftLast = CntW'(SoftRstCycles - 1);
  localparam logic [CntW-1:0] CntTop = CntW'(CntMax);

  hart_srst_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic tmo_q, tmo_d, soft_q, hold_q, ack_q;

  // next state; idle is checked before the timeout so a same-cycle idle wins
  always_comb begin
    state_d = state_q;
    cnt_d = (cnt_q == CntTop) ? cnt_q : cnt_q + 1'b1;
    tmo_d = tmo_q;
    case (state_q)
      IDLE: if (run_i && req_i) begin
        state_d = DRAIN;
        cnt_d = '0;
      end
      DRAIN: if (idle_i || cnt_q == DrainLast) begin
        state_d = ASSERT;
        cnt_d = '0;
        tmo_d = tmo_q | ~idle_i;
      end
      ASSERT: state_d = (cnt_q == SoftLast) ? ACK : ASSERT;
      ACK: state_d = WAIT;
      WAIT: state_d = req_i ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, counter and registered outputs decoded from the next state
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tmo_q <= 1'b0;
      soft_q <= 1'b0;
      hold_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      soft_q <= rel_d_i && (state_d != ASSERT);
      hold_q <= (state_d == DRAIN) || (state_d == ASSERT);
      ack_q <= state_d == ACK;
    end
  end

  assign soft_rstn_o = soft_q;
  assign fetch_hold_o = hold_q;
  assign ack_o = ack_q;
  assign timeout_o = tmo_q;
endmodule

// File: rtl/drac_tile_reset_seq.sv
// drac_tile_reset_seq: reset synchroniser, wake-up delay, staggered hart release and soft resets
module drac_tile_reset_seq
  import drac_pkg::*;
#(
  parameter int unsigned NHarts        = 1,
  parameter int unsigned SyncStages    = 2,
  parameter int unsigned WakeUpCycles  = 32768,
  parameter int unsigned StaggerCycles = 16,
  parameter int unsigned DrainTimeout  = 1024,
  parameter int unsigned SoftRstCycles = 16
) (
  input  logic              clk_i,
  input  logic              reset_l,
  output logic              spc_grst_l,
  output logic [NHarts-1:0] rst_n_o,
  output logic [NHarts-1:0] soft_rstn_o,
  input  logic [NHarts-1:0] soft_rst_req_i,
  input  logic [NHarts-1:0] hart_idle_i,
  output logic [NHarts-1:0] fetch_hold_o,
  output logic [NHarts-1:0] soft_rst_ack_o,
  output logic [NHarts-1:0] timeout_o,
  output logic              seq_done_o
);
  localparam int unsigned GMax = WakeUpCycles > StaggerCycles ? WakeUpCycles : StaggerCycles;
  localparam int unsigned GW = $clog2(GMax + 1);
  localparam int unsigned IdxW = NHarts > 1 ? $clog2(NHarts) : 1;
  localparam logic [GW-1:0] WakeLast = GW'(WakeUpCycles - 1);
  localparam logic [GW-1:0] StagLast = GW'(StaggerCycles - 1);
  localparam logic [GW-1:0] CntTop = GW'(GMax);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NHarts - 1);

  logic [SyncStages-1:0] sync_q;
  logic rst_sync_n;
  rst_seq_state_t state_q, state_d;
  logic [GW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [NHarts-1:0] rel_q, rel_d;
  logic rel_now;

  // deassert synchroniser: clears asynchronously, shifts a 1 in on release
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) sync_q <= '0;
    else sync_q <= {sync_q[SyncStages-2:0], 1'b1};
  end

  assign rst_sync_n = sync_q[SyncStages-1];

  // wake-up count starts on the first synchronised-high cycle so hart 0 frees at SyncStages+WakeUpCycles
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    rel_d = rel_q;
    rel_now = 1'b0;
    case (state_q)
      RESET, WAKEUP: if (rst_sync_n) begin
        state_d = WAKEUP;
        rel_now = cnt_q == WakeLast;
        cnt_d = (cnt_q == CntTop) ? cnt_q : cnt_q + 1'b1;
      end
      RELEASE: begin
        rel_now = cnt_q == StagLast;
        cnt_d = (cnt_q == CntTop) ? cnt_q : cnt_q + 1'b1;
      end
      default: ;
    endcase
    if (rel_now) begin
      for (int i = 0; i < NHarts; i++) if (idx_q == IdxW'(i)) rel_d[i] = 1'b1;
      idx_d = idx_q + 1'b1;
      cnt_d = '0;
      state_d = (idx_q == IdxLast) ? RUN : RELEASE;
    end
  end

  // global sequencer registers
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= RESET;
      cnt_q <= '0;
      idx_q <= '0;
      rel_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      rel_q <= rel_d;
    end
  end

  assign spc_grst_l = rst_sync_n;
  assign rst_n_o = rel_q;
  assign seq_done_o = state_q == RUN;

  for (genvar i = 0; i < NHarts; i++) begin : g_hart
    drac_hart_soft_rst #(
      .DrainTimeout (DrainTimeout),
      .SoftRstCycles(SoftRstCycles)
    ) u_hart (
      .clk_i       (clk_i),
      .reset_l     (reset_l),
      .run_i       (state_q == RUN),
      .rel_d_i     (rel_d[i]),
      .req_i       (soft_rst_req_i[i]),
      .idle_i      (hart_idle_i[i]),
      .soft_rstn_o (soft_rstn_o[i]),
      .fetch_hold_o(fetch_hold_o[i]),
      .ack_o       (soft_rst_ack_o[i]),
      .timeout_o   (timeout_o[i])
    );
  end
endmodule

// File: tb/tb_drac_tile_reset_seq.sv
// tb_drac_tile_reset_seq: scoreboard bench for the tile reset sequencer
module tb_drac_tile_reset_seq;
  localparam int N = 4;
  typedef enum int {E_GRST, E_REL, E_DONE, E_HOLD1, E_SOFT0, E_SOFT1, E_ACK, E_HOLD0, E_TMO, E_BAD} ev_k;
  typedef struct {ev_k k; int h; int c;} ev_t;

  logic clk_i = 1'b0, reset_l = 1'b0;
  logic spc_grst_l, seq_done_o;
  logic [N-1:0] rst_n_o, soft_rstn_o, fetch_hold_o, soft_rst_ack_o, timeout_o;
  logic [N-1:0] soft_rst_req_i = '0, hart_idle_i = '0;
  int cyc = 0, t0 = 0, n_chk = 0, n_fail = 0;
  ev_t exp_q[5][$];
  logic pg = 1'b0, pd = 1'b0;
  logic [N-1:0] pr = '0, ps = '0, ph = '0, pt = '0;

  drac_tile_reset_seq #(
    .NHarts(N), .SyncStages(2), .WakeUpCycles(100), .StaggerCycles(10),
    .DrainTimeout(64), .SoftRstCycles(16)
  ) dut (
    .clk_i(clk_i), .reset_l(reset_l), .spc_grst_l(spc_grst_l), .rst_n_o(rst_n_o),
    .soft_rstn_o(soft_rstn_o), .soft_rst_req_i(soft_rst_req_i), .hart_idle_i(hart_idle_i),
    .fetch_hold_o(fetch_hold_o), .soft_rst_ack_o(soft_rst_ack_o), .timeout_o(timeout_o),
    .seq_done_o(seq_done_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic push(input int ch, input ev_k k, input int h, input int c);
    ev_t e;
    e.k = k; e.h = h; e.c = c;
    exp_q[ch].push_back(e);
  endtask

  task automatic push_soft(input int h, input int t, input int d, input bit tmo);
    push(h, E_HOLD1, h, t);
    push(h, E_SOFT0, h, d);
    if (tmo) push(h, E_TMO, h, d);
    push(h, E_SOFT1, h, d + 16);
    push(h, E_ACK, h, d + 16);
    push(h, E_HOLD0, h, d + 16);
  endtask

  task automatic got(input int ch, input ev_k k, input int h);
    ev_t e;
    n_chk++;
    if (exp_q[ch].size() == 0) begin
      n_fail++;
      $display("FAIL ev ch%0d: got %s h%0d @%0d, required nothing", ch, k.name(), h, cyc - t0);
    end else begin
      e = exp_q[ch].pop_front();
      if (e.k != k || e.h != h || e.c != cyc - t0) begin
        n_fail++;
        $display("FAIL ev ch%0d: got %s h%0d @%0d, required %s h%0d @%0d",
                 ch, k.name(), h, cyc - t0, e.k.name(), e.h, e.c);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grst"}, 32'(spc_grst_l), 0);
    chk({tag, "_rstn"}, 32'(rst_n_o), 0);
    chk({tag, "_soft"}, 32'(soft_rstn_o), 0);
    chk({tag, "_hold"}, 32'(fetch_hold_o), 0);
    chk({tag, "_ack"}, 32'(soft_rst_ack_o), 0);
    chk({tag, "_tmo"}, 32'(timeout_o), 0);
    chk({tag, "_done"}, 32'(seq_done_o), 0);
  endtask

  task automatic wait_to(input int n);
    @(negedge clk_i);
    while (cyc - t0 < n) @(negedge clk_i);
    #1;
  endtask

  // monitor: turns output transitions into events and scores them against the queues
  always @(negedge clk_i) begin
    if (reset_l) begin
      if (spc_grst_l && !pg) got(4, E_GRST, 0);
      if (!spc_grst_l && pg) got(4, E_BAD, 0);
      for (int i = 0; i < N; i++) begin
        if (rst_n_o[i] && !pr[i]) got(4, E_REL, i);
        if (!rst_n_o[i] && pr[i]) got(4, E_BAD, i);
      end
      if (seq_done_o && !pd) got(4, E_DONE, 0);
      if (!seq_done_o && pd) got(4, E_BAD, 0);
      for (int i = 0; i < N; i++) begin
        if (fetch_hold_o[i] && !ph[i]) got(i, E_HOLD1, i);
        if (!soft_rstn_o[i] && ps[i]) got(i, E_SOFT0, i);
        if (soft_rstn_o[i] && !ps[i]) got(i, E_SOFT1, i);
        if (soft_rst_ack_o[i]) got(i, E_ACK, i);
        if (!fetch_hold_o[i] && ph[i]) got(i, E_HOLD0, i);
        if (timeout_o[i] && !pt[i]) got(i, E_TMO, i);
        if (!timeout_o[i] && pt[i]) got(i, E_BAD, i);
      end
    end
    pg <= spc_grst_l;
    pd <= seq_done_o;
    pr <= rst_n_o;
    ps <= soft_rstn_o;
    ph <= fetch_hold_o;
    pt <= timeout_o;
  end

  initial begin
    repeat (3) @(negedge clk_i);
    #1;
    check_zero("por");
    reset_l = 1'b1;
    t0 = cyc;
    push(4, E_GRST, 0, 2);
    wait_to(50);
    reset_l = 1'b0;
    #1;
    check_zero("mid");
    chk("grst_seen", 32'(exp_q[4].size()), 0);
    repeat (3) @(negedge clk_i);
    #1;
    check_zero("held");
    reset_l = 1'b1;
    t0 = cyc;
    push(4, E_GRST, 0, 2);
    for (int h = 0; h < N; h++) begin
      push(4, E_REL, h, 102 + 10 * h);
      push(h, E_SOFT1, h, 102 + 10 * h);
    end
    push(4, E_DONE, 0, 132);
    wait_to(119);
    soft_rst_req_i[2] = 1'b1;
    hart_idle_i[2] = 1'b1;
    push_soft(2, 133, 134, 1'b0);
    wait_to(180);
    soft_rst_req_i[2] = 1'b0;
    wait_to(190);
    soft_rst_req_i[2] = 1'b1;
    push_soft(2, 191, 192, 1'b0);
    wait_to(215);
    soft_rst_req_i[2] = 1'b0;
    hart_idle_i[2] = 1'b0;
    wait_to(220);
    soft_rst_req_i[1] = 1'b1;
    push_soft(1, 221, 241, 1'b0);
    wait_to(240);
    chk("h1_hold", 32'(fetch_hold_o[1]), 1);
    hart_idle_i[1] = 1'b1;
    wait_to(245);
    hart_idle_i[1] = 1'b0;
    wait_to(260);
    soft_rst_req_i[1] = 1'b0;
    wait_to(270);
    soft_rst_req_i[0] = 1'b1;
    push_soft(0, 271, 335, 1'b1);
    wait_to(355);
    soft_rst_req_i[0] = 1'b0;
    wait_to(400);
    soft_rst_req_i = '1;
    push_soft(0, 401, 405, 1'b0);
    push_soft(1, 401, 410, 1'b0);
    push_soft(2, 401, 415, 1'b0);
    push_soft(3, 401, 465, 1'b1);
    wait_to(404);
    hart_idle_i[0] = 1'b1;
    wait_to(409);
    hart_idle_i[1] = 1'b1;
    wait_to(414);
    hart_idle_i[2] = 1'b1;
    wait_to(490);
    soft_rst_req_i = '0;
    hart_idle_i = '0;
    wait_to(500);
    soft_rst_req_i[1] = 1'b1;
    push_soft(1, 501, 565, 1'b0);
    wait_to(564);
    hart_idle_i[1] = 1'b1;
    wait_to(590);
    soft_rst_req_i = '0;
    hart_idle_i = '0;
    wait_to(620);
    chk("end_tmo", 32'(timeout_o), 32'h9);
    chk("end_rstn", 32'(rst_n_o), 32'hf);
    chk("end_soft", 32'(soft_rstn_o), 32'hf);
    chk("end_hold", 32'(fetch_hold_o), 0);
    chk("end_done", 32'(seq_done_o), 1);
    for (int ch = 0; ch < 5; ch++) chk($sformatf("left_ch%0d", ch), 32'(exp_q[ch].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/drac_tile_reset_seq.md
# drac_tile_reset_seq

Parametrised reset and wake-up sequencer for multi-hart Sargantana tiles in OpenPiton. It replaces the fixed 2^15-cycle wake-up counter and ungated `spc_grst_l` flop in the tile wrapper with four functions:
- a reset synchroniser;
- a configurable wake-up delay;
- staggered per-hart release;
- a per-hart soft-reset service with drain handshake and timeout.

It sits between the tile's `reset_l` and each `top_tile` instance's `rstn_i`/`soft_rstn_i`.

## Interface
- `NHarts`, 1, number of harts sequenced (≥1).
- `SyncStages`, 2, reset-deassert synchroniser depth (≥2).
- `WakeUpCycles`, 32768, cycles between synchronised deassert and first hart release (≥1).
- `StaggerCycles`, 16, cycles between consecutive hart releases (≥1).
- `DrainTimeout`, 1024, maximum DRAIN cycles before soft reset is forced (≥1).
- `SoftRstCycles`, 16, soft-reset low pulse width (≥1).

Ports:
- `clk_i` in 1: core clock.
- `reset_l` in 1: asynchronous, active-low reset. Together with `clk_i`, this is already decided.
- `spc_grst_l` out 1: synchronised global reset, active-low.
- `rst_n_o` out NHarts: per-hart hard reset to `top_tile.rstn_i`, active-low.
- `soft_rstn_o` out NHarts: per-hart soft reset, active-low. It is the AND of `rst_n_o[i]` and the soft-pulse state.
- `soft_rst_req_i` in NHarts: level request for a hart soft reset.
- `hart_idle_i` in NHarts: hart has backend empty and no outstanding L1.5 transactions.
- `fetch_hold_o` out NHarts: blocks new fetch and memory requests while the hart drains.
- `soft_rst_ack_o` out NHarts: one-cycle pulse when a soft reset completes.
- `timeout_o` out NHarts: sticky; set when a drain timed out. Cleared only by `reset_l`.
- `seq_done_o` out 1: all harts released.

## Operation
Synchroniser:
- `reset_l` low clears all `SyncStages` flops asynchronously.
- On deassert, a 1 shifts through the chain. The internal `rst_sync_n` is the last flop.
- `spc_grst_l = rst_sync_n`.

Global FSM, reset into RESET:
- RESET → WAKEUP when `rst_sync_n` is 1.
- WAKEUP: the counter counts 0..WakeUpCycles-1, then → RELEASE with the hart index at 0.
- RELEASE: set `rst_n_o[idx]` = 1, then wait StaggerCycles and increment idx.
  - After hart NHarts-1 is released → RUN.
  - With NHarts=1, go directly to RUN after the first release.
- RUN: `seq_done_o` = 1. This is a terminal state until reset.

Per-hart soft-reset FSM, reset into IDLE:
- IDLE: when `soft_rst_req_i[i]` = 1 and global state is RUN → DRAIN.
  - Requests made before RUN are held, not dropped, because the input is a level.
- DRAIN: `fetch_hold_o[i]` = 1 and the timeout counter runs.
  - When `hart_idle_i[i]` = 1 → ASSERT.
  - At count DrainTimeout-1 without idle → ASSERT and set `timeout_o[i]`.
  - If idle and timeout occur in the same cycle, idle wins and `timeout_o` is not set.
- ASSERT: `soft_rstn_o[i]` = 0 and `fetch_hold_o[i]` = 1 for SoftRstCycles cycles → ACK.
- ACK: `soft_rst_ack_o[i]` = 1 for one cycle, `fetch_hold_o` = 0 → WAIT.
- WAIT: return to IDLE when `soft_rst_req_i[i]` = 0. A held request never retriggers.

General rules:
- Harts are independent; simultaneous requests are serviced in parallel.
- Counters are `$clog2(max+1)` bits and saturate; they never wrap.
- `reset_l` low at any time, including mid-WAKEUP or mid-DRAIN, asynchronously returns every FSM to its reset state.

## Timing
Reset values: `spc_grst_l`, `rst_n_o`, `soft_rstn_o`, `fetch_hold_o`, `soft_rst_ack_o`, `timeout_o` and `seq_done_o` are all 0.

Release timing, with `reset_l` rising before edge 1:
- `spc_grst_l` = 1 after edge SyncStages.
- `rst_n_o[0]` = 1 after edge SyncStages+WakeUpCycles.
- `rst_n_o[i]` = 1 after edge SyncStages+WakeUpCycles+i·StaggerCycles.
- `seq_done_o` rises together with the last `rst_n_o` bit.

Soft-reset timing:
- Request sampled at edge t moves to DRAIN, so `fetch_hold_o` is 1 after t.
- Idle sampled at edge d: `soft_rstn_o` is low from d to d+SoftRstCycles, and the ack pulse follows in the next cycle.

All outputs are registered. `soft_rstn_o` deassertion is synchronous.

## Structure
- `drac_pkg` holds `rst_seq_state_t` (RESET, WAKEUP, RELEASE, RUN) and `hart_srst_state_t` (IDLE, DRAIN, ASSERT, ACK, WAIT).
- Sub-module `drac_hart_soft_rst` (per-hart FSM plus counters) is instantiated NHarts times in a generate loop.
- The global FSM and synchroniser stay in the top module.

## Test plan
- NHarts=4, WakeUpCycles=100, StaggerCycles=10, SyncStages=2, release `reset_l` at cycle 0 → `spc_grst_l` at 2, `rst_n_o` bits at 102/112/122/132, `seq_done_o` at 132.
- Reset mid-WAKEUP: drop `reset_l` at cycle 50 for 3 cycles → all outputs 0 immediately; the sequence restarts from scratch.
- Soft reset on hart 1, `hart_idle_i[1]` rises 20 cycles after the request, SoftRstCycles=16 → hold for 20 cycles, low pulse for 16 cycles, ack 1 cycle, `timeout_o[1]` stays 0.
- DrainTimeout=64, hart never idle → ASSERT at cycle 64, `timeout_o` is set and remains set through later soft resets.
- Request held before `seq_done_o` → serviced starting the cycle after RUN. A held request after ACK produces no second reset until it deasserts and reasserts.
- Simultaneous requests on all 4 harts with different idle times → independent completions; `rst_n_o` is unaffected throughout.
